ps2_rx_frame: RTL

PS/2 receive front end for the keyboard demo path. It sits directly upstream of the scan-code display and LED logic. The block synchronizes and de-glitches the raw ps2_clk/ps2_dat lines, deserializes 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop), and delivers each byte with a one-cycle valid strobe. Parity errors, framing errors and stalled frames are flagged instead of delivered.

---
 rtl/ps2_rx_frame_if.sv | 21 ++
 rtl/ps2_rx_frame.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame_if.sv
// PS/2 receive bundle: raw line inputs toward the receiver and decoded
// byte/status strobes back to the consumer.
interface ps2_rx_frame_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_timeout;
  logic       rx_busy;

  modport master (
    output ps2_clk, ps2_dat,
    input  rx_data, rx_valid, rx_err, rx_timeout, rx_busy
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output rx_data, rx_valid, rx_err, rx_timeout, rx_busy
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronize and de-glitch both lines,
// deserialize start/8 data/odd parity/stop, and strobe the byte or an error.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic           CLOCK_50,
  input logic           Resetn,
  ps2_rx_frame_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 0 carries ps2_clk, index 1 carries ps2_dat.
  logic [1:0]    r_sync1, r_sync2, r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_clk_prev;

  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_data;
  logic          r_valid, r_err, r_timeout, r_busy;

  logic w_fall, w_dat;
  assign w_fall = r_clk_prev & ~r_filt[0];
  assign w_dat  = r_filt[1];

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_filt     <= '1;
      r_clk_prev <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_sync1    <= {bus.ps2_dat, bus.ps2_clk};
      r_sync2    <= r_sync1;
      r_clk_prev <= r_filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_fcnt[i] == FMAX) begin
            r_filt[i] <= r_sync2[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + 1'b1;
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_par     <= 1'b0;
      r_tcnt    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;

      if (r_state == IDLE || w_fall) r_tcnt <= '0;
      else if (r_tcnt != TMAX)       r_tcnt <= r_tcnt + 1'b1;

      // The timeout only fires on a cycle without a fall, so a late edge wins.
      if (r_state != IDLE && !w_fall && r_tcnt == TMAX) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_timeout <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_dat) begin
              r_state  <= DATA;
              r_busy   <= 1'b1;
              r_bitcnt <= '0;
            end
          end
          DATA: begin
            r_shift[r_bitcnt] <= w_dat;
            r_bitcnt          <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
          STOP: begin
            if (w_dat && (^{r_shift, r_par})) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.rx_err     = r_err;
  assign bus.rx_timeout = r_timeout;
  assign bus.rx_busy    = r_busy;
endmodule
